// File: rtl/trace_equiv_checker.sv
`default_nettype none
// ============================================================================
// Module   : trace_equiv_checker
// Purpose  : Skew-tolerant in-order compare of per-copy observation streams,
//            each buffered in its own FIFO. Optional macro TEC_ADDR_CMP_EN
//            also stores and compares the dmem address field.
// Revision : 1.0  initial release
// ============================================================================
module trace_equiv_checker #(
  parameter int NCOPY    = 2,
  parameter int CNT_W    = 2,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_SKEW = 8
) (
  input  logic                    clk,
  input  logic                    reset_x,
  input  logic                    check_en,
  input  logic [NCOPY-1:0]        obs_valid,
  input  logic [NCOPY*CNT_W-1:0]  obs_cnt,
  input  logic [NCOPY*ADDR_W-1:0] obs_addr,
  output logic                    violation,
  output logic [1:0]              viol_code,
  output logic [2:0]              viol_copy,
  output logic [15:0]             match_cnt
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;
  localparam int c_sw = $clog2(MAX_SKEW + 1);
`ifdef TEC_ADDR_CMP_EN
  localparam int c_ew = CNT_W + ADDR_W;
`else
  localparam int c_ew = CNT_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_pw-1:0]  r_wp [NCOPY];
  logic [c_pw-1:0]  r_rp [NCOPY];
  logic [c_ew-1:0]  r_mem [NCOPY][DEPTH];
  logic [c_sw-1:0]  r_skew;
  logic             r_violation;
  logic [1:0]       r_code;
  logic [2:0]       r_copy;
  logic [15:0]      r_match;

  logic [c_ew-1:0]  w_entry [NCOPY];
  logic [c_ew-1:0]  w_head  [NCOPY];
  logic [NCOPY-1:0] w_empty, w_full, w_push, w_mis, w_ovf;
  logic             w_active, w_pop, w_skew_cond, w_timeout;
  logic [2:0]       w_mis_idx, w_ovf_idx, w_emp_idx;

`ifndef TEC_ADDR_CMP_EN
  logic w_unused_addr;
  assign w_unused_addr = ^obs_addr;
`endif

  assign w_active    = (r_state == S_RUN) && check_en;
  assign w_pop       = w_active && !(|w_empty);
  assign w_skew_cond = (|w_empty) && !(&w_empty);
  assign w_timeout   = w_active && w_skew_cond && (r_skew == c_sw'(MAX_SKEW - 1));

  generate
    for (genvar gi = 0; gi < NCOPY; gi++) begin : g_copy
`ifdef TEC_ADDR_CMP_EN
      assign w_entry[gi] = {obs_cnt[gi*CNT_W +: CNT_W], obs_addr[gi*ADDR_W +: ADDR_W]};
`else
      assign w_entry[gi] = obs_cnt[gi*CNT_W +: CNT_W];
`endif
      assign w_head[gi]  = r_mem[gi][r_rp[gi][c_aw-1:0]];
      assign w_empty[gi] = (r_wp[gi] == r_rp[gi]);
      assign w_full[gi]  = (r_wp[gi][c_aw] != r_rp[gi][c_aw]) &&
                           (r_wp[gi][c_aw-1:0] == r_rp[gi][c_aw-1:0]);
      // A full FIFO still accepts a write when the heads pop this cycle
      assign w_push[gi]  = w_active && obs_valid[gi] && (!w_full[gi] || w_pop);
      assign w_ovf[gi]   = w_active && obs_valid[gi] && w_full[gi] && !w_pop;
      if (gi == 0) begin : g_ref
        assign w_mis[gi] = 1'b0;
      end else begin : g_cmp
        assign w_mis[gi] = w_pop && (w_head[gi] != w_head[0]);
      end
    end
  endgenerate

  // Lowest offending index wins: scan high to low, last hit sticks
  always_comb begin
    w_mis_idx = 3'd0;
    w_ovf_idx = 3'd0;
    w_emp_idx = 3'd0;
    for (int i = NCOPY - 1; i >= 0; i--) begin
      if (w_mis[i])   w_mis_idx = 3'(i);
      if (w_ovf[i])   w_ovf_idx = 3'(i);
      if (w_empty[i]) w_emp_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCOPY; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i][c_aw-1:0]] <= w_entry[i];
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state     <= S_IDLE;
      r_skew      <= '0;
      r_violation <= 1'b0;
      r_code      <= 2'd0;
      r_copy      <= 3'd0;
      r_match     <= 16'd0;
      for (int i = 0; i < NCOPY; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_skew <= '0;
          for (int i = 0; i < NCOPY; i++) begin
            r_wp[i] <= '0;
            r_rp[i] <= '0;
          end
          if (check_en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!check_en) begin
            r_state <= S_IDLE;
            r_skew  <= '0;
            for (int i = 0; i < NCOPY; i++) begin
              r_wp[i] <= '0;
              r_rp[i] <= '0;
            end
          end else begin
            for (int i = 0; i < NCOPY; i++) begin
              if (w_push[i]) r_wp[i] <= r_wp[i] + c_pw'(1);
              if (w_pop)     r_rp[i] <= r_rp[i] + c_pw'(1);
            end
            r_skew <= w_skew_cond ? r_skew + c_sw'(1) : '0;
            if (w_pop && !(|w_mis) && (r_match != 16'hFFFF))
              r_match <= r_match + 16'd1;
            if (|w_mis) begin
              r_state     <= S_FAIL;
              r_violation <= 1'b1;
              r_code      <= 2'd1;
              r_copy      <= w_mis_idx;
            end else if (|w_ovf) begin
              r_state     <= S_FAIL;
              r_violation <= 1'b1;
              r_code      <= 2'd2;
              r_copy      <= w_ovf_idx;
            end else if (w_timeout) begin
              r_state     <= S_FAIL;
              r_violation <= 1'b1;
              r_code      <= 2'd3;
              r_copy      <= w_emp_idx;
            end
          end
        end
        default: begin
          r_state <= S_FAIL;
        end
      endcase
    end
  end

  assign violation = r_violation;
  assign viol_code = r_code;
  assign viol_copy = r_copy;
  assign match_cnt = r_match;

endmodule
`default_nettype wire
